// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: program counter, next-PC selection and the IF/ID
// pipeline register, with a saturating count of valid fetches.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_if,
  input  logic             flush_if,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      ifid_pc4,
  output logic [31:0]      ifid_instr,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ifid_pc4_q, ifid_pc4_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  assign imem_addr   = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign ifid_pc4    = ifid_pc4_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_valid  = ifid_valid_q;
  assign fetch_count = fetch_count_q;

  // Next PC: a redirect beats a stall; targets are word-aligned before loading.
  always_comb begin
    pc_d = pc_plus4;
    if (branch_taken) begin
      pc_d = {branch_target[31:2], 2'b00};
    end else if (jump) begin
      pc_d = {jump_target[31:2], 2'b00};
    end else if (stall_if) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_plus4;
    end
  end

  // IF/ID next state: a flush wins over a stall; the counter only advances on a valid load.
  always_comb begin
    ifid_pc4_d    = ifid_pc4_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;
    if (flush_if) begin
      ifid_pc4_d   = 32'h0000_0000;
      ifid_instr_d = NOP_WORD;
      ifid_valid_d = 1'b0;
    end else if (stall_if) begin
      ifid_pc4_d   = ifid_pc4_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
    end else begin
      ifid_pc4_d   = pc_plus4;
      ifid_instr_d = imem_rdata;
      ifid_valid_d = 1'b1;
      if (fetch_count_q != CNT_MAX) begin
        fetch_count_d = fetch_count_q + CNT_ONE;
      end else begin
        fetch_count_d = fetch_count_q;
      end
    end
  end

  // State registers with asynchronous reset to the fetch-from-RESET_PC state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      ifid_pc4_q    <= 32'h0000_0000;
      ifid_instr_q  <= NOP_WORD;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= {CNT_W{1'b0}};
    end else begin
      pc_q          <= pc_d;
      ifid_pc4_q    <= ifid_pc4_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program counter and computes PC+4 with a 32-bit wrapping adder. It selects the next PC from sequential, branch or jump redirects and drives the instruction-memory address. It holds the IF/ID pipeline register that feeds decode, with stall and flush controls from the hazard unit.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset (sll $0,$0,0).
CNT_W, 16, width of the saturating fetched-instruction counter.

Ports:
clk  in  1  pipeline clock, rising-edge.
reset  in  1  asynchronous, active-high reset.
stall_if  in  1  hazard unit: hold PC and IF/ID contents.
flush_if  in  1  load a bubble into IF/ID (taken branch/jump resolved in ID).
branch_taken  in  1  redirect PC to branch_target this cycle.
branch_target  in  32  branch target computed in ID.
jump  in  1  redirect PC to jump_target this cycle.
jump_target  in  32  jump target computed in ID.
imem_addr  out  32  instruction memory address; equals current PC.
imem_rdata  in  32  instruction word; combinational read of imem_addr.
pc_plus4  out  32  current PC + 4, combinational.
ifid_pc4  out  32  registered PC+4 of the instruction in IF/ID.
ifid_instr  out  32  registered instruction word.
ifid_valid  out  1  1 = IF/ID holds a real fetched instruction; 0 = bubble.
fetch_count  out  CNT_W  number of instructions loaded into IF/ID with valid=1, saturating.

Behaviour:
- Reset is asynchronous and active-high. While asserted: PC=RESET_PC, ifid_instr=NOP_WORD, ifid_pc4=0, ifid_valid=0, fetch_count=0. Outputs take these values immediately, without waiting for a clock edge.
- imem_addr=PC and pc_plus4=PC+32'd4 are combinational. The sum is modulo 2^32, so 32'hFFFF_FFFC gives 32'h0000_0000.
- Next-PC selection, highest priority first:
  - branch_taken: branch_target.
  - jump: jump_target.
  - stall_if: hold PC.
  - otherwise: pc_plus4.
- A redirect overrides stall_if for the PC. Bits [1:0] of the selected target are forced to 0 before loading.
- IF/ID update at each rising edge, highest priority first:
  - flush_if: ifid_instr=NOP_WORD, ifid_pc4=0, ifid_valid=0.
  - stall_if: hold all IF/ID fields.
  - otherwise: ifid_instr=imem_rdata, ifid_pc4=pc_plus4, ifid_valid=1.
- flush_if together with stall_if gives a flush. A redirect without flush_if is legal and still loads IF/ID with the sequential fetch; the hazard unit normally asserts both.
- Latency: the instruction at PC appears on ifid_instr one edge after it is addressed. A redirect takes effect on the PC at the same edge, and the target instruction reaches IF/ID one edge later.
- fetch_count increments by 1 on every edge where IF/ID loads with valid=1. It holds at 2^CNT_W-1 and does not wrap.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values at once. The first edge after deassertion fetches from RESET_PC.
- No X propagation: every register has a defined reset value, and the next-state logic has a default branch.

Test Plan:
- Reset then 3 free-running edges, imem returns addr^32'hA5A5_0000 → PC 0→4→8→C; ifid_instr=32'hA5A5_0000/0004/0008; ifid_pc4=4/8/C; fetch_count=3.
- At PC=8, stall_if high for 2 edges → PC stays 8; IF/ID holds instr of PC=4 and pc4=8; fetch_count unchanged; resumes at 8 on release.
- At PC=C, branch_taken=1, branch_target=32'h0000_0103, flush_if=1 → next PC=32'h100, ifid_valid=0, ifid_instr=NOP_WORD; next edge ifid_instr=word@0x100, ifid_pc4=32'h104.
- branch_taken and jump both high with targets 0x200 and 0x300, stall_if=1 → PC=0x200. Then jump alone with target 0x300 → PC=0x300.
- Force PC to 32'hFFFF_FFFC via jump → pc_plus4=0. The next edge loads PC=0 and ifid_pc4=0 with valid=1.
- Reset pulse asserted between edges during a stall → outputs reach reset values before the next edge. Separately, with CNT_W=4, run 20 free fetches → fetch_count saturates at 15.
